// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer feeding the serial sequence detectors.
// A holding register backs the shift register so consecutive words stream without gaps.
module piso_bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    input  logic             flush,
    input  logic             clr_flags,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             underrun
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state, state_nxt;
    logic               hold_full, hold_full_nxt;
    logic [WIDTH-1:0]   hold_reg;
    logic [WIDTH-1:0]   shift_reg, shift_nxt;
    logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
    logic               x_out_nxt, x_valid_nxt, underrun_nxt;
    logic               accept;
    logic               cur_bit;
    logic [WIDTH-1:0]   shifted;

    assign in_ready = ~hold_full & ~flush;
    assign accept   = in_valid & in_ready;
    assign busy     = (state == SHIFT) | hold_full;

    assign cur_bit = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0}
                               : {1'b0, shift_reg[WIDTH-1:1]};

    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_nxt     = state;
        hold_full_nxt = hold_full;
        shift_nxt     = shift_reg;
        cnt_nxt       = bit_cnt;
        x_out_nxt     = x_out;
        x_valid_nxt   = 1'b0;
        // A new underrun in the same cycle as clr_flags must win.
        underrun_nxt  = (underrun & ~clr_flags) | (bit_en & (state == IDLE));

        if (flush) begin
            state_nxt     = IDLE;
            hold_full_nxt = 1'b0;
            cnt_nxt       = '0;
            x_out_nxt     = IDLE_BIT;
        end else begin
            // accept requires an empty hold, so it never collides with a reload below.
            if (accept) hold_full_nxt = 1'b1;

            unique case (state)
                IDLE: begin
                    x_out_nxt = IDLE_BIT;
                    if (hold_full) begin
                        shift_nxt     = hold_reg;
                        cnt_nxt       = CNT_W'(WIDTH);
                        hold_full_nxt = 1'b0;
                        state_nxt     = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        x_out_nxt   = cur_bit;
                        x_valid_nxt = 1'b1;
                        shift_nxt   = shifted;
                        cnt_nxt     = bit_cnt - CNT_W'(1);
                        if (bit_cnt == CNT_W'(1)) begin
                            if (hold_full) begin
                                shift_nxt     = hold_reg;
                                cnt_nxt       = CNT_W'(WIDTH);
                                hold_full_nxt = 1'b0;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            x_out     <= IDLE_BIT;
            x_valid   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_full <= hold_full_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
            x_out     <= x_out_nxt;
            x_valid   <= x_valid_nxt;
            underrun  <= underrun_nxt;
        end
    end

    // NOTE: hold_reg is pure datapath guarded by hold_full, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept) hold_reg <= in_data;
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Scoreboard bench for piso_bit_serializer: an MSB-first and an LSB-first instance share stimulus;
// directed scenarios check timing, flush, underrun and async reset, then a random run streams words.
module tb_piso_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data   = '0;
    logic         in_valid  = 1'b0;
    logic         bit_en    = 1'b0;
    logic         flush     = 1'b0;
    logic         clr_flags = 1'b0;

    logic in_ready_a, x_out_a, x_valid_a, busy_a, underrun_a;
    logic in_ready_b, x_out_b, x_valid_b, busy_b, underrun_b;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .bit_en(bit_en), .flush(flush), .clr_flags(clr_flags), .x_out(x_out_a),
        .x_valid(x_valid_a), .busy(busy_a), .underrun(underrun_a)
    );

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .bit_en(bit_en), .flush(flush), .clr_flags(clr_flags), .x_out(x_out_b),
        .x_valid(x_valid_b), .busy(busy_b), .underrun(underrun_b)
    );

    int checks   = 0;
    int failures = 0;

    bit   q_a[$];
    bit   q_b[$];
    logic tr_v_a[32], tr_x_a[32], tr_v_b[32], tr_x_b[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        return msb ? w[W-1-i] : w[i];
    endfunction

    function automatic logic [31:0] exp_stream(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                               input int nw, input bit msb);
        logic [31:0] s = '0;
        for (int j = 0; j < nw; j++)
            for (int i = 0; i < W; i++)
                s = {s[30:0], exp_bit((j == 0) ? w0 : w1, i, msb)};
        return s;
    endfunction

    function automatic logic [31:0] pack(input logic v[32]);
        logic [31:0] p = '0;
        for (int k = 0; k < 32; k++) p[k] = v[k];
        return p;
    endfunction

    // Scoreboard: every accepted word expands into its expected bit order; every x_valid pops one bit.
    always @(negedge clk) begin
        if (rst) begin
            if (x_valid_a) begin
                if (q_a.size() == 0) check("sb_a_spurious_valid", x_valid_a, 1'b0);
                else                 check("sb_a_bit", x_out_a, q_a.pop_front());
            end
            if (x_valid_b) begin
                if (q_b.size() == 0) check("sb_b_spurious_valid", x_valid_b, 1'b0);
                else                 check("sb_b_bit", x_out_b, q_b.pop_front());
            end
            if (flush) begin
                q_a.delete();
                q_b.delete();
            end else if (in_valid && in_ready_a) begin
                for (int i = 0; i < W; i++) begin
                    q_a.push_back(exp_bit(in_data, i, 1'b1));
                    q_b.push_back(exp_bit(in_data, i, 1'b0));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record outputs after each edge; bit_en is either continuous or one pulse every 'period' edges.
    task automatic capture(input int n, input int period);
        for (int k = 0; k < 32; k++) begin
            tr_v_a[k] = 1'b0; tr_x_a[k] = 1'b0; tr_v_b[k] = 1'b0; tr_x_b[k] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_v_a[k] = x_valid_a; tr_x_a[k] = x_out_a;
            tr_v_b[k] = x_valid_b; tr_x_b[k] = x_out_b;
            step();
            bit_en = (period == 1) ? 1'b1 : (((k + 2) % period) == 0);
        end
    endtask

    task automatic analyze(input int n, input logic v[32], input logic x[32], output int cnt,
                           output int run, output logic [31:0] s, output int holdbad);
        int cur   = 0;
        int first = -1;
        int last  = -1;
        cnt = 0; run = 0; s = '0; holdbad = 0;
        for (int k = 0; k < n; k++) begin
            if (v[k]) begin
                cnt++; cur++;
                if (cur > run) run = cur;
                s = {s[30:0], x[k]};
                if (first < 0) first = k;
                last = k;
            end else begin
                cur = 0;
            end
        end
        if (first >= 0)
            for (int k = first + 1; k <= last; k++)
                if (!v[k] && x[k] !== x[k-1]) holdbad++;
    endtask

    int          cnt, run, holdbad;
    logic [31:0] s;

    initial begin
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x_out_a", x_out_a, 1'b0);
        check("rst_x_out_b", x_out_b, 1'b1);
        check("rst_x_valid_a", x_valid_a, 1'b0);
        check("rst_in_ready_a", in_ready_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_underrun_a", underrun_a, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Single word, continuous bit_en: first bit two edges after acceptance.
        in_data = 8'hA5; in_valid = 1'b1; bit_en = 1'b1;
        step();
        in_valid = 1'b0;
        capture(12, 1);
        check("t1_valid_window_a", pack(tr_v_a) & 32'hFFF, 32'h3FC);
        check("t1_valid_window_b", pack(tr_v_b) & 32'hFFF, 32'h3FC);
        analyze(12, tr_v_a, tr_x_a, cnt, run, s, holdbad);
        check("t1_stream_a", s, exp_stream(8'hA5, 8'h00, 1, 1'b1));
        analyze(12, tr_v_b, tr_x_b, cnt, run, s, holdbad);
        check("t1_stream_b", s, exp_stream(8'hA5, 8'h00, 1, 1'b0));
        check("t1_idle_x_a", tr_x_a[10], 1'b0);
        check("t1_idle_x_b", tr_x_b[10], 1'b1);
        @(negedge clk);
        check("t1_busy_a", busy_a, 1'b0);
        check("t1_underrun_a", underrun_a, 1'b1);

        // Back-to-back words with in_valid held: 16 gapless emissions.
        in_data = 8'h0A; in_valid = 1'b1; bit_en = 1'b1;
        step();
        in_data = 8'hA0;
        @(negedge clk);
        check("t2_ready_hold_full", in_ready_a, 1'b0);
        step();
        @(negedge clk);
        check("t2_ready_after_load", in_ready_a, 1'b1);
        step();
        in_valid = 1'b0;
        capture(20, 1);
        check("t2_valid_window_a", pack(tr_v_a) & 32'hFFFFF, 32'h0FFFF);
        analyze(20, tr_v_a, tr_x_a, cnt, run, s, holdbad);
        check("t2_run_a", run, 16);
        check("t2_stream_a", s, exp_stream(8'h0A, 8'hA0, 2, 1'b1));
        analyze(20, tr_v_b, tr_x_b, cnt, run, s, holdbad);
        check("t2_run_b", run, 16);
        check("t2_stream_b", s, exp_stream(8'h0A, 8'hA0, 2, 1'b0));

        // Sparse bit_en: one bit per third edge, held between pulses.
        bit_en = 1'b0; in_data = 8'hC3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        capture(30, 3);
        analyze(30, tr_v_a, tr_x_a, cnt, run, s, holdbad);
        check("t3_count_a", cnt, 8);
        check("t3_pulse_len_a", run, 1);
        check("t3_stream_a", s, exp_stream(8'hC3, 8'h00, 1, 1'b1));
        check("t3_hold_a", holdbad, 0);
        analyze(30, tr_v_b, tr_x_b, cnt, run, s, holdbad);
        check("t3_stream_b", s, exp_stream(8'hC3, 8'h00, 1, 1'b0));
        check("t3_hold_b", holdbad, 0);

        // Underrun: set on bit_en in IDLE, sticky across a word, cleared by clr_flags, set wins.
        bit_en = 1'b0; clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        @(negedge clk);
        check("t4_cleared_a", underrun_a, 1'b0);
        check("t4_cleared_b", underrun_b, 1'b0);
        bit_en = 1'b1;
        step();
        bit_en = 1'b0;
        @(negedge clk);
        check("t4_no_emit", x_valid_a, 1'b0);
        check("t4_idle_x_b", x_out_b, 1'b1);
        check("t4_underrun_set", underrun_a, 1'b1);
        in_data = 8'h3C; in_valid = 1'b1; bit_en = 1'b1;
        step();
        in_valid = 1'b0;
        capture(12, 1);
        analyze(12, tr_v_a, tr_x_a, cnt, run, s, holdbad);
        check("t4_word_count", cnt, 8);
        check("t4_sticky", underrun_a, 1'b1);
        bit_en = 1'b1; clr_flags = 1'b1;
        step();
        bit_en = 1'b0; clr_flags = 1'b0;
        @(negedge clk);
        check("t4_set_wins", underrun_a, 1'b1);
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        @(negedge clk);
        check("t4_clear_again", underrun_a, 1'b0);

        // Flush after three bits with a second word waiting in hold.
        in_data = 8'hF0; in_valid = 1'b1; bit_en = 1'b1;
        step();
        in_data = 8'h55;
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        @(negedge clk);
        check("t5_busy_before", busy_a, 1'b1);
        check("t5_ready_in_flush", in_ready_a, 1'b0);
        step();
        flush = 1'b0;
        @(negedge clk);
        check("t5_x_out_a", x_out_a, 1'b0);
        check("t5_x_out_b", x_out_b, 1'b1);
        check("t5_x_valid", x_valid_a, 1'b0);
        check("t5_busy", busy_a, 1'b0);
        check("t5_ready_after", in_ready_a, 1'b1);
        capture(12, 1);
        analyze(12, tr_v_a, tr_x_a, cnt, run, s, holdbad);
        check("t5_nothing_left", cnt, 0);
        bit_en = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        check("t5_ready_flush_empty", in_ready_a, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("t5_no_accept_in_flush", busy_a, 1'b0);

        // LSB-first ordering, then asynchronous reset mid-word.
        in_data = 8'h01; in_valid = 1'b1; bit_en = 1'b1;
        step();
        in_valid = 1'b0;
        capture(5, 1);
        check("t6_first_bit_a", tr_x_a[2], exp_bit(8'h01, 0, 1'b1));
        check("t6_first_bit_b", tr_x_b[2], exp_bit(8'h01, 0, 1'b0));
        check("t6_second_bit_b", tr_x_b[3], exp_bit(8'h01, 1, 1'b0));
        #2;
        rst = 1'b0;
        q_a.delete();
        q_b.delete();
        #1;
        check("t6_async_x_out_a", x_out_a, 1'b0);
        check("t6_async_x_out_b", x_out_b, 1'b1);
        check("t6_async_x_valid_b", x_valid_b, 1'b0);
        check("t6_async_busy_a", busy_a, 1'b0);
        check("t6_async_busy_b", busy_b, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Random streaming with occasional flushes; the scoreboard checks every emitted bit.
        for (int n = 0; n < 1500; n++) begin
            in_data   = W'($urandom);
            in_valid  = ($urandom % 3) != 0;
            bit_en    = ($urandom % 4) != 0;
            flush     = ($urandom % 50) == 0;
            clr_flags = ($urandom % 20) == 0;
            step();
        end
        in_valid = 1'b0; flush = 1'b0; clr_flags = 1'b0; bit_en = 1'b1;
        repeat (40) step();
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
        check("drain_busy_a", busy_a, 1'b0);
        check("drain_ready_a", in_ready_a, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_bit_serializer.md
Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the serial sequence detectors.
- Accepts WIDTH-bit words over a valid/ready handshake and emits one bit per bit_en strobe on x_out, which drives the detector's x input.
- Double-buffered (holding register plus shift register), so back-to-back words stream without gaps.
- Provides flush, idle-fill and underrun reporting.

Parameters:
WIDTH, 8, word width in bits (≥2)
MSB_FIRST, 1, 1 = bit WIDTH-1 emitted first; 0 = bit 0 emitted first
IDLE_BIT, 0, value driven on x_out when no word is being shifted

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_data  input  WIDTH  parallel word
in_valid  input  1  in_data valid
in_ready  output  1  holding register can accept; = ~hold_full & ~flush
bit_en  input  1  pacing strobe; one bit emitted per asserted cycle
flush  input  1  synchronous discard of all buffered data
clr_flags  input  1  synchronous clear of underrun
x_out  output  1  serial bit (registered), to detector x
x_valid  output  1  registered; high for exactly the cycle after each emission
busy  output  1  state==SHIFT | hold_full
underrun  output  1  sticky: bit_en seen with no data available

Behaviour:
- Reset (rst=0, async): state=IDLE, hold_full=0, shift register and bit counter cleared, x_out=IDLE_BIT, x_valid=0, underrun=0. in_ready=1 and busy=0 once reset is held.
- Accept: in_valid & in_ready at an edge -> hold_reg<=in_data, hold_full<=1. No accept while hold_full=1.
- States: IDLE (shift register empty), SHIFT (bits remaining; bit_cnt = WIDTH..1).
- IDLE:
  - hold_full=1 -> load shift from hold, bit_cnt<=WIDTH, hold_full<=0, go to SHIFT.
  - bit_en in the same cycle emits nothing.
- SHIFT with bit_en=1:
  - x_out<=current bit (MSB or LSB per MSB_FIRST), x_valid<=1, shift by one, bit_cnt-1.
  - On the last bit (bit_cnt==1): if hold_full=1, reload shift from hold, clear hold_full, stay in SHIFT (gapless). Otherwise go to IDLE.
- SHIFT with bit_en=0: hold state; x_out keeps its last value; x_valid<=0.
- In IDLE with no emission: x_out<=IDLE_BIT, x_valid<=0.
- Latency: accept at edge T -> shift loaded at T+1 -> first emission at first bit_en edge ≥T+2; bit visible on x_out after that edge (T+2 with continuous bit_en).
- Word boundary with continuous bit_en: the new word accepted before the last bit of the current word continues with no idle cycle. A word accepted on the last-bit edge lands in hold; IDLE reloads next cycle, giving one idle cycle (x_out=IDLE_BIT).
- Underrun: bit_en=1 while state==IDLE -> underrun<=1, sticky. Clears only via clr_flags or reset. If clr_flags and a new underrun occur in the same cycle, set wins.
- Flush (sync, highest priority over accept/shift/load):
  - next edge: state=IDLE, hold_full=0, bit_cnt=0, x_out=IDLE_BIT, x_valid=0.
  - in_ready=0 during the flush cycle; underrun is unaffected.
- Reset mid-word: all outputs return to reset values immediately; partial word is lost.
- bit_cnt width: $clog2(WIDTH+1).

Test Plan:
1. WIDTH=8, MSB_FIRST=1, bit_en=1 constant, single word 8'hA5 accepted at T -> x_out = 1,0,1,0,0,1,0,1 at T+2..T+9, x_valid high exactly those 8 cycles, then x_out=0, busy=0, underrun=1 (bit_en in IDLE).
2. Back-to-back 8'h0A then 8'hA0, in_valid held -> in_ready low while hold full; 16 consecutive x_valid cycles with no gap, stream 0000101010100000; the downstream 1010 detector pulses at the expected overlapping positions.
3. bit_en every 3rd cycle, word 8'hC3 -> each x_out bit held 3 cycles; x_valid a single-cycle pulse per bit; total 8 pulses, sequence 11000011.
4. bit_en pulses with no word loaded -> x_valid=0, x_out=IDLE_BIT, underrun=1 and stays 1 across a later word; clr_flags pulse -> 0 next edge.
5. Flush after 3 bits of 8'hF0 with 8'h55 in hold -> next edge x_out=0, x_valid=0, busy=0, remaining bits never emitted; in_ready=1 after flush deasserts.
6. MSB_FIRST=0, word 8'h01 -> first bit 1, then seven 0s. Assert rst mid-word -> x_out=IDLE_BIT, x_valid=0, busy=0 asynchronously, before the next clock edge.
